// File: rtl/scic_io_ctrl_if.sv
// I/O bus between the SCIC core (master) and the switch/LED responder (slave).
// Single-cycle strobes, registered read data with a one-cycle valid pulse.
interface scic_io_ctrl_if;
    logic [1:0] io_addr;
    logic       io_wr;
    logic [3:0] io_wdata;
    logic       io_rd;
    logic [3:0] io_rdata;
    logic       io_rvalid;
    logic       irq;

    modport master (
        output io_addr, io_wr, io_wdata, io_rd,
        input  io_rdata, io_rvalid, irq
    );

    modport slave (
        input  io_addr, io_wr, io_wdata, io_rd,
        output io_rdata, io_rvalid, irq
    );
endinterface

// File: rtl/scic_io_ctrl.sv
// Switch/LED I/O responder: synchronises and debounces 4 switches, holds the LED
// register, latches sticky change flags and raises a masked level interrupt.
module scic_io_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [3:0]    switches,
    output logic [3:0]    LEDs,
    scic_io_ctrl_if.slave io
);

    typedef enum logic [1:0] {
        ADDR_SW  = 2'd0,
        ADDR_LED = 2'd1,
        ADDR_CHG = 2'd2,
        ADDR_IEN = 2'd3
    } reg_addr_e;

    // Terminal count; the counter restarts here, so it never needs to wrap.
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       stable_q, stable_d;
    logic [3:0][15:0] cnt_q, cnt_d;
    logic [3:0]       chg_q, chg_d, chg_set, chg_clr;
    logic [3:0]       led_q, led_d;
    logic [3:0]       ien_q, ien_d;
    logic [3:0]       rdata_q, rdata_d, rd_mux;
    logic             rvalid_q, rvalid_d;
    logic             irq_q, irq_d;
    reg_addr_e        addr;

    assign addr = reg_addr_e'(io.io_addr);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two synchroniser stages.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= switches;
            sync2_q <= sync1_q;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        chg_set  = '0;
        for (int b = 0; b < 4; b++) begin
            if (sync2_q[b] == stable_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CNT_LAST) begin
                stable_d[b] = sync2_q[b];
                cnt_d[b]    = '0;
                chg_set[b]  = 1'b1;
            end else begin
                cnt_d[b] = cnt_q[b] + 16'd1;
            end
        end
    end

    always_comb begin
        led_d   = led_q;
        ien_d   = ien_q;
        chg_clr = '0;
        if (io.io_wr) begin
            case (addr)
                ADDR_SW:  ;
                ADDR_LED: led_d   = io.io_wdata;
                ADDR_CHG: chg_clr = io.io_wdata;
                ADDR_IEN: ien_d   = io.io_wdata;
            endcase
        end
        // A flag set by the debouncer this cycle survives a concurrent clear.
        chg_d = (chg_q & ~chg_clr) | chg_set;
        irq_d = |(chg_q & ien_q);
    end

    always_comb begin
        rd_mux = stable_q;
        case (addr)
            ADDR_SW:  rd_mux = stable_q;
            ADDR_LED: rd_mux = led_q;
            ADDR_CHG: rd_mux = chg_q;
            ADDR_IEN: rd_mux = ien_q;
        endcase
        rvalid_d = io.io_rd;
        rdata_d  = io.io_rd ? rd_mux : rdata_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable_q <= '0;
            cnt_q    <= '0;
            chg_q    <= '0;
            led_q    <= '0;
            ien_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            chg_q    <= chg_d;
            led_q    <= led_d;
            ien_q    <= ien_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
        end
    end

    assign LEDs         = led_q;
    assign io.io_rdata  = rdata_q;
    assign io.io_rvalid = rvalid_q;
    assign io.irq       = irq_q;

endmodule

// File: tb/tb_scic_io_ctrl.sv
// Bench for scic_io_ctrl: directed scenarios plus random traffic, checked by a
// scoreboard fed from a behavioural model of the register map and debouncer.
module tb_scic_io_ctrl;
    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] switches = 4'b1010;
    logic [3:0] leds;
    logic [3:0] sw_lvl = 4'b1010;

    scic_io_ctrl_if bus ();

    scic_io_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clock    (clock),
        .reset    (reset),
        .switches (switches),
        .LEDs     (leds),
        .io       (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] m_sw, m_led, m_chg, m_ien;
    logic [3:0] m_delay[$];   // raw switch samples still travelling through the synchroniser
    int         run[4];       // consecutive synchronised cycles disagreeing with the accepted level
    logic       exp_irq;
    logic [3:0] sb_q[$];

    function automatic logic [3:0] reg_value(input logic [1:0] a);
        case (a)
            2'd0:    return m_sw;
            2'd1:    return m_led;
            2'd2:    return m_chg;
            default: return m_ien;
        endcase
    endfunction

    task automatic model_reset();
        m_sw = '0; m_led = '0; m_chg = '0; m_ien = '0;
        m_delay = '{4'h0, 4'h0};
        for (int b = 0; b < 4; b++) run[b] = 0;
        exp_irq = 1'b0;
        sb_q.delete();
    endtask

    // Advances the model across the coming clock edge, given the inputs now driven.
    task automatic model_step(input logic [1:0] a, input logic w, input logic [3:0] wd, input logic r);
        logic [3:0] synced, set, clr;
        if (r) sb_q.push_back(reg_value(a));
        synced = m_delay.pop_front();
        m_delay.push_back(switches);
        set = '0;
        for (int b = 0; b < 4; b++) begin
            if (synced[b] != m_sw[b]) begin
                run[b]++;
                if (run[b] == D) begin
                    set[b] = 1'b1;
                    run[b] = 0;
                end
            end else begin
                run[b] = 0;
            end
        end
        exp_irq = |(m_chg & m_ien);
        clr = '0;
        if (w) begin
            case (a)
                2'd1:    m_led = wd;
                2'd2:    clr   = wd;
                2'd3:    m_ien = wd;
                default: ;
            endcase
        end
        m_sw  = m_sw ^ set;
        m_chg = (m_chg & ~clr) | set;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input logic rst, input logic [1:0] a, input logic w,
                         input logic [3:0] wd, input logic r);
        @(negedge clock);
        reset        = rst;
        switches     = sw_lvl;
        bus.io_addr  = a;
        bus.io_wr    = w;
        bus.io_wdata = wd;
        bus.io_rd    = r;
        if (!rst) model_reset();
        else      model_step(a, w, wd, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 2'd0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic rd(input logic [1:0] a);
        cycle(1'b1, a, 1'b0, 4'h0, 1'b1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        cycle(1'b1, a, 1'b1, d, 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clock);
            #2;
            check("leds", leds, m_led);
            check("irq", bus.irq, exp_irq);
            if (bus.io_rvalid) begin
                if (sb_q.size() == 0) check("rvalid_unexpected", 1, 0);
                else                  check("rdata", bus.io_rdata, sb_q.pop_front());
            end else if (sb_q.size() != 0) begin
                check("rvalid_missing", 0, 1);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // ---------------- scenarios ----------------
    initial begin
        int bit_idx;
        bus.io_addr = '0; bus.io_wr = 1'b0; bus.io_wdata = '0; bus.io_rd = 1'b0;
        model_reset();

        // Reset held with switches high, then a normal debounce after release.
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 1'b0, 4'h0, 1'b0);
        #1 check("reset_outputs", {leds, bus.io_rdata, bus.io_rvalid, bus.irq}, 10'h0);
        idle(1);
        for (int i = 0; i < 7; i++) rd(2'd0);
        rd(2'd2);

        // Glitch of 3 synchronised cycles, then a genuine change.
        sw_lvl = 4'b0000; idle(8);
        wr(2'd2, 4'b1111);
        sw_lvl = 4'b0001; idle(3);
        sw_lvl = 4'b0000;
        for (int i = 0; i < 6; i++) rd(2'd0);
        rd(2'd2);
        sw_lvl = 4'b0001;
        for (int i = 0; i < 10; i++) rd(2'd0);
        rd(2'd2);

        // LED path and read-only SW.
        wr(2'd1, 4'b0110);
        rd(2'd1);
        wr(2'd0, 4'b1111);
        rd(2'd0);
        cycle(1'b1, 2'd1, 1'b1, 4'b1001, 1'b1);   // same-cycle read returns old LED value
        rd(2'd1);

        // Interrupt set, clear, and masked change.
        wr(2'd2, 4'b1111);
        wr(2'd3, 4'b0100);
        sw_lvl = 4'b0101; idle(8);
        wr(2'd2, 4'b0100);
        idle(2);
        sw_lvl = 4'b0100; idle(8);
        rd(2'd2);
        rd(2'd3);

        // Debounce completion on the same edge as a write-1-clear of that bit.
        wr(2'd2, 4'b1111);
        sw_lvl = 4'b0110; idle(1);
        idle(4);
        wr(2'd2, 4'b0010);
        rd(2'd2);
        rd(2'd0);

        // Reset during a read and during a debounce count.
        wr(2'd3, 4'b1111);
        sw_lvl = 4'b1110; idle(3);
        cycle(1'b0, 2'd1, 1'b0, 4'h0, 1'b1);
        #1 check("reset_mid_outputs", {leds, bus.io_rvalid, bus.irq}, 6'h0);
        cycle(1'b0, 2'd1, 1'b0, 4'h0, 1'b1);
        #1 check("reset_mid_rdata", bus.io_rdata, 4'h0);
        for (int i = 0; i < 8; i++) rd(2'd0);
        rd(2'd2);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                bit_idx = int'($urandom_range(0, 3));
                sw_lvl[bit_idx] = ~sw_lvl[bit_idx];
            end
            cycle($urandom_range(0, 199) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 2) == 0, 4'($urandom), $urandom_range(0, 1) == 1);
        end

        idle(3);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/scic_io_ctrl.md
# scic_io_ctrl

Memory-mapped I/O responder between the SCIC core's I/O bus and the board's 4 slide switches and 4 LEDs. It serves the other end of the core's switch-read / LED-write accesses: it synchronises and debounces the raw switches, holds the LED output register, and latches per-bit switch-change flags. An optional level interrupt tells the core that a debounced switch changed, so programs need not poll.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised switch bit must differ from its stable value before the change is accepted. Legal range 1–65535. Use 4 for simulation; large values for the 125 MHz board.

Ports:
- clock, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- switches, input, 4: raw, asynchronous slide-switch levels.
- LEDs, output, 4: LED drive, straight from the LED register.
- io_addr, input, 2: register select.
- io_wr, input, 1: write strobe, one cycle per access.
- io_wdata, input, 4: write data.
- io_rd, input, 1: read strobe, one cycle per access.
- io_rdata, output, 4: registered read data.
- io_rvalid, output, 1: one-cycle pulse, io_rdata valid.
- irq, output, 1: registered level interrupt.

## Operation

- Register map:
  - addr 0 SW: debounced switch state, read-only; writes ignored.
  - addr 1 LED: read/write; drives LEDs.
  - addr 2 CHG: sticky change flags; read; write-1-to-clear per bit.
  - addr 3 IEN: interrupt enable mask, read/write.
- Input path, per bit:
  - 2-flop synchroniser (sync1 → sync2).
  - 16-bit counter cnt, compared against stable.
  - If sync2 == stable: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable ← sync2, cnt ← 0, CHG bit ← 1.
  - Else: cnt ← cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles leaves stable and CHG untouched.
- CHG set and a write-1-clear on the same bit in the same cycle: set wins, bit stays 1.
- irq ← |(CHG & IEN), registered.
- Reads: io_rd at edge E latches the addressed register's pre-edge value into io_rdata, with io_rvalid=1 during cycle E..E+1. io_rvalid=0 otherwise. io_rdata holds its last value between reads.
- io_rd and io_wr in the same cycle to the same address: the write takes effect and the read returns the old value.
- Accesses need no wait states; back-to-back strobes every cycle are legal.
- Reset (asserted at any time, including mid-debounce or mid-read): sync1, sync2, stable, and all cnt = 0; LED = 0, CHG = 0, IEN = 0; LEDs = 0, io_rdata = 0, io_rvalid = 0, irq = 0. An in-flight read is dropped (no rvalid).
- After reset release with switches already high: a normal debounce occurs, so stable updates and CHG is set for those bits.

## Timing

- Switch change captured into sync1 at edge k:
  - sync2 updates at k+1.
  - stable and CHG update at k+1+DEBOUNCE_CYCLES.
  - irq asserts at k+2+DEBOUNCE_CYCLES (if enabled).
- LED write at edge E: LEDs change at E.
- Read latency is 1 cycle (strobe edge to data valid).
- CHG cleared at edge E: irq deasserts at E+1.
- Counter never wraps: it is reset at DEBOUNCE_CYCLES-1, so DEBOUNCE_CYCLES=65535 is safe.

## Test plan

- Reset: hold reset=0 for 3 cycles with switches=4'b1010 → every output 0. Release → with DEBOUNCE_CYCLES=4, SW reads 4'b1010 and CHG reads 4'b1010 from edge k+5 onward.
- Debounce: switches 0000→0001 held 3 synced cycles then back to 0000 → SW stays 0000, CHG stays 0000. Then hold 0001 for 10 cycles → SW=0001 exactly at edge k+5.
- LED path: write addr1=4'b0110 → LEDs=0110 the same edge. Read addr1 → io_rdata=0110 with one io_rvalid pulse. Write addr0=1111 → SW unchanged.
- Interrupt: IEN=0100, then switch bit2 rises → irq=1 at k+6. Write CHG=0100 → irq=0 one cycle later. Bit0 change with IEN bit0=0 → irq stays 0, CHG bit0=1.
- Simultaneous set/clear: time a CHG write-1 of bit1 on the same edge bit1's debounce completes → CHG bit1 reads 1.
- Reset mid-operation: assert reset during a read strobe and mid-count → no io_rvalid; after release the count restarts from 0 (full DEBOUNCE_CYCLES needed).
